// File: rtl/ktc32_mem_pkg.sv
// Shared memory-interface types for the ktc32 core, the LSU and the memory models.
package ktc32_mem_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    BYTE = 2'b01,
    HALF = 2'b10,
    WORD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

  // Request attributes latched at accept and held for the whole transaction
  typedef struct packed {
    logic      we;
    mem_size_e size;
    logic      sext;
    logic      err;
  } lsu_ctl_t;

endpackage

// File: rtl/ktc32_load_ext.sv
// Combinational load extender: picks the low byte/half/word of the read data
// and sign- or zero-extends it to DATA_W bits.
module ktc32_load_ext
  import ktc32_mem_pkg::*;
(
  input  logic [DATA_W-1:0] rd_i,
  input  mem_size_e         size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] data_c
);

  always_comb begin
    data_c = '0;
    case (size_i)
      BYTE:    data_c = {{(DATA_W-8){signed_i & rd_i[7]}}, rd_i[7:0]};
      HALF:    data_c = {{(DATA_W-16){signed_i & rd_i[15]}}, rd_i[15:0]};
      WORD:    data_c = rd_i;
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/ktc32_lsu.sv
// ktc32 load/store initiator: one request at a time, registered memory port
// with WAIT_CYCLES wait states, registered extended load response.
module ktc32_lsu
  import ktc32_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned CNT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] wd,
  output logic [1:0]        memwrite,
  input  logic [DATA_W-1:0] rd
);

  if (WAIT_CYCLES > (2 ** CNT_W) - 1) begin : g_wait_check
    $error("ktc32_lsu: WAIT_CYCLES does not fit in CNT_W bits");
  end

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  lsu_ctl_t          ctl_q, ctl_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  mem_size_e         memwrite_q, memwrite_d;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] ext_data;
  mem_size_e         req_size_e;

  assign req_size_e = mem_size_e'(req_size);

  ktc32_load_ext u_load_ext (
    .rd_i     (rd),
    .size_i   (ctl_q.size),
    .signed_i (ctl_q.sext),
    .data_c   (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ctl_q        <= '0;
      addr_q       <= '0;
      wd_q         <= '0;
      memwrite_q   <= NONE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ctl_q        <= ctl_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
      memwrite_q   <= memwrite_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // The strobe is registered, so it is raised on the edge that enters the
  // final ACCESS cycle (counter reaching zero). A reserved size still spends
  // one strobe-less ACCESS cycle so every response has the same minimum latency.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ctl_d        = ctl_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    memwrite_d   = NONE;
    ready_d      = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid) begin
          ready_d    = 1'b0;
          state_d    = ACCESS;
          ctl_d.we   = req_we;
          ctl_d.size = req_size_e;
          ctl_d.sext = req_signed;
          ctl_d.err  = (req_size_e == NONE);
          if (req_size_e == NONE) begin
            cnt_d = '0;
          end else begin
            addr_d = req_addr;
            wd_d   = req_wdata;
            cnt_d  = CNT_W'(WAIT_CYCLES);
            if (req_we && (WAIT_CYCLES == 0)) memwrite_d = req_size_e;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if ((cnt_q == CNT_W'(1)) && ctl_q.we && !ctl_q.err) memwrite_d = ctl_q.size;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = ctl_q.err;
          resp_rdata_d = (ctl_q.we || ctl_q.err) ? '0 : ext_data;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign addr       = addr_q;
  assign wd         = wd_q;
  assign memwrite   = memwrite_q;

endmodule

// File: tb/tb_ktc32_lsu.sv
// Scoreboard bench for ktc32_lsu: one instance with WAIT_CYCLES=0, one with 3,
// each attached to a small byte memory model.
module tb_ktc32_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [1:0]  req_size   [2];
  logic        req_signed [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [31:0] addr       [2];
  logic [31:0] wd         [2];
  logic [1:0]  memwrite   [2];
  logic [31:0] rd         [2];

  ktc32_lsu #(.WAIT_CYCLES(0), .CNT_W(4)) u_lsu0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .addr(addr[0]), .wd(wd[0]),
    .memwrite(memwrite[0]), .rd(rd[0])
  );

  ktc32_lsu #(.WAIT_CYCLES(3), .CNT_W(4)) u_lsu3 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .addr(addr[1]), .wd(wd[1]),
    .memwrite(memwrite[1]), .rd(rd[1])
  );

  // Byte memories, preloaded on the first edge, committing on memwrite
  logic [7:0] mem [2][256];
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 256; j++) mem[i][j] <= 8'h00;
      mem[0][8'h40] <= 8'h80; mem[0][8'h41] <= 8'h12;
      mem[0][8'h42] <= 8'h34; mem[0][8'h43] <= 8'hF6;
      mem[1][8'h50] <= 8'h11; mem[1][8'h51] <= 8'h22;
      mem[1][8'h52] <= 8'h33; mem[1][8'h53] <= 8'h44;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (memwrite[i] != 2'b00) mem[i][addr[i][7:0]] <= wd[i][7:0];
        if (memwrite[i][1]) mem[i][addr[i][7:0] + 8'd1] <= wd[i][15:8];
        if (memwrite[i] == 2'b11) begin
          mem[i][addr[i][7:0] + 8'd2] <= wd[i][23:16];
          mem[i][addr[i][7:0] + 8'd3] <= wd[i][31:24];
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_rd
    assign rd[g] = {mem[g][addr[g][7:0] + 8'd3], mem[g][addr[g][7:0] + 8'd2],
                    mem[g][addr[g][7:0] + 8'd1], mem[g][addr[g][7:0]]};
  end

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } side_t;

  exp_t  exp_q[$];
  side_t side_q[$];
  int    errors = 0;
  int    checks = 0;
  int    mw_cnt [2] = '{0, 0};
  int    mw_cyc [2] = '{0, 0};
  logic [1:0] mw_val [2] = '{2'b00, 2'b00};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every resp_valid, tracks strobes,
  // and evaluates side checks posted by the stimulus.
  initial begin
    exp_t  e;
    side_t s;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst[i] && memwrite[i] != 2'b00) begin
          mw_cnt[i]++;
          mw_cyc[i] = cyc;
          mw_val[i] = memwrite[i];
        end
        if (resp_valid[i]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp inst=%0d: got rdata=%h err=%b, required no response",
                     i, resp_rdata[i], resp_err[i]);
          end else begin
            e = exp_q.pop_front();
            chk({e.name, "_inst"}, 32'(i), 32'(e.inst));
            chk({e.name, "_rdata"}, resp_rdata[i], e.rdata);
            chk({e.name, "_err"}, {31'b0, resp_err[i]}, {31'b0, e.err});
            chk({e.name, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
          end
        end
      end
      while (side_q.size() > 0) begin
        s = side_q.pop_front();
        chk(s.name, s.act, s.exp);
      end
    end
  end

  task automatic side(input string nm, input logic [31:0] act, input logic [31:0] exp);
    side_t s;
    s.name = nm;
    s.act  = act;
    s.exp  = exp;
    side_q.push_back(s);
  endtask

  // Call at a negedge; returns at the negedge of the first ACCESS cycle.
  task automatic issue(input int i, input logic we, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wdat,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input bit push, input bit hold, input string nm, output int acc);
    int budget = 0;
    req_we[i]     = we;
    req_size[i]   = sz;
    req_signed[i] = sx;
    req_addr[i]   = a;
    req_wdata[i]  = wdat;
    req_valid[i]  = 1'b1;
    while (!req_ready[i] && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    acc = cyc;
    if (!req_ready[i]) begin
      side({nm, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid[i] = 1'b0;
      return;
    end
    if (push) begin
      exp_t e;
      e.inst  = i;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.lat   = (i == 0) ? 2 : 5;
      e.acc   = cyc;
      e.name  = nm;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (!hold) req_valid[i] = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      side("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int a0, a1, b;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'b00;
      req_signed[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      side("rst_ready", {31'b0, req_ready[i]}, 32'd1);
      side("rst_resp_valid", {31'b0, resp_valid[i]}, 32'd0);
      side("rst_memwrite", {30'b0, memwrite[i]}, 32'd0);
      side("rst_addr", addr[i], 32'd0);
      side("rst_wd", wd[i], 32'd0);
      side("rst_rdata", resp_rdata[i], 32'd0);
      side("rst_err", {31'b0, resp_err[i]}, 32'd0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    issue(0, 1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1, 1'b0, "ld_b_s", a0);
    wait_drain();
    issue(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h00001280, 1'b0, 1'b1, 1'b0, "ld_h_u", a0);
    wait_drain();
    issue(0, 1'b0, 2'b11, 1'b1, 32'h41, 32'h0, 32'h00F63412, 1'b0, 1'b1, 1'b0, "ld_w_unal", a0);
    side("ld_w_addr_access", addr[0], 32'h41);
    wait_drain();
    side("ld_w_addr_hold", addr[0], 32'h41);

    b = mw_cnt[1];
    issue(1, 1'b1, 2'b10, 1'b0, 32'h50, 32'h0000BEEF, 32'h0, 1'b0, 1'b1, 1'b0, "st_h", a0);
    side("st_h_addr", addr[1], 32'h50);
    side("st_h_wd", wd[1], 32'h0000BEEF);
    wait_drain();
    side("st_h_mw_count", 32'(mw_cnt[1] - b), 32'd1);
    side("st_h_mw_val", {30'b0, mw_val[1]}, 32'd2);
    side("st_h_mw_lat", 32'(mw_cyc[1] - a0), 32'd4);
    side("st_h_m50", {24'b0, mem[1][8'h50]}, 32'hEF);
    side("st_h_m51", {24'b0, mem[1][8'h51]}, 32'hBE);
    side("st_h_m52", {24'b0, mem[1][8'h52]}, 32'h33);

    issue(1, 1'b0, 2'b01, 1'b1, 32'h51, 32'h0, 32'hFFFFFFBE, 1'b0, 1'b1, 1'b0, "ld_b_s_w3", a0);
    wait_drain();

    b = mw_cnt[0];
    issue(0, 1'b0, 2'b00, 1'b0, 32'h60, 32'h0000FFFF, 32'h0, 1'b1, 1'b1, 1'b0, "size_err", a0);
    wait_drain();
    side("size_err_no_write", 32'(mw_cnt[0] - b), 32'd0);

    b = mw_cnt[1];
    issue(1, 1'b1, 2'b11, 1'b0, 32'h50, 32'h00000004, 32'h0, 1'b0, 1'b0, 1'b0, "rst_mid", a0);
    @(negedge clk);
    rst[1] = 1'b1;
    side("rst_mid_memwrite", {30'b0, memwrite[1]}, 32'd0);
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    repeat (10) @(negedge clk);
    side("rst_mid_no_write", 32'(mw_cnt[1] - b), 32'd0);
    side("rst_mid_m50", {24'b0, mem[1][8'h50]}, 32'hEF);
    side("rst_mid_m53", {24'b0, mem[1][8'h53]}, 32'h44);
    side("rst_mid_ready", {31'b0, req_ready[1]}, 32'd1);

    issue(0, 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'h00000034, 1'b0, 1'b1, 1'b1, "b2b_1", a0);
    issue(0, 1'b0, 2'b10, 1'b1, 32'h42, 32'h0, 32'hFFFFF634, 1'b0, 1'b1, 1'b0, "b2b_2", a1);
    side("b2b_spacing", 32'(a1 - a0), 32'd3);
    wait_drain();

    side("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1);
  end

endmodule
